data_ram: RTL

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram.sv | 101 ++++++++++
 1 files changed

// File: rtl/data_ram.sv
// data_ram: byte-addressed 32-bit word RAM with sized little-endian loads/stores,
// one-cycle response latency and an optional zero-fill sweep after reset.
module data_ram #(
  parameter int ADDR_W         = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int WA    = ADDR_W - 2;
  localparam int DEPTH = 1 << WA;
  localparam logic [WA-1:0] LAST = '1;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e        state_q, state_d;
  logic          rst_q;
  logic [WA-1:0] ptr_q, ptr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [31:0]   mem_q [DEPTH];

  logic          accept, mis;
  logic [1:0]    off;
  logic [WA-1:0] word_idx, wr_idx;
  logic [3:0]    lane_mask, lane_we;
  logic [31:0]   rd_word, wr_data, ld_data;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

  // rst_q keeps busy asserted while n_rst is low, even when reset lands directly in RUN
  assign busy      = rst_q || state_q == CLEAR;
  assign req_ready = !busy;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    off       = req_addr[1:0];
    word_idx  = req_addr[ADDR_W-1:2];
    accept    = req_valid && req_ready;
    mis       = req_size == 2'b11 || (req_size == 2'b01 && off[0]) || (req_size == 2'b10 && off != 2'b00);
    rd_word   = mem_q[word_idx];
    ld_b      = rd_word[8*off +: 8];
    ld_h      = rd_word[16*off[1] +: 16];
    ld_data   = req_size == 2'b00 ? {{24{ld_b[7] && !req_unsigned}}, ld_b} :
                req_size == 2'b01 ? {{16{ld_h[15] && !req_unsigned}}, ld_h} : rd_word;
    lane_mask = req_size == 2'b00 ? 4'b0001 << off :
                req_size == 2'b01 ? 4'b0011 << off : 4'b1111;
    state_d   = state_q;
    ptr_d     = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d   = ptr_q + 1'b1;
      state_d = ptr_q == LAST ? RUN : CLEAR;
    end
    wr_idx      = state_q == CLEAR ? ptr_q : word_idx;
    wr_data     = state_q == CLEAR ? 32'd0 :
                  req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                  req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    lane_we     = state_q == CLEAR ? {4{n_rst}} :
                  (accept && req_we && !mis) ? lane_mask : 4'b0000;
    rsp_valid_d = accept;
    rsp_err_d   = accept && mis;
    rsp_rdata_d = (accept && !req_we && !mis) ? ld_data : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
      rst_q       <= 1'b1;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      rst_q       <= 1'b0;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (lane_we[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
  end
endmodule
